// File: rtl/paddle_controller.sv
// rtl/paddle_controller.sv - per-frame paddle position FSM with clamping to the playfield
// Optional acceleration while a direction is held: define PADDLE_ACCEL_EN.
module paddle_controller #(
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 80,
  parameter int Y_W          = 10,
  parameter int STEP         = 4,
  parameter int MAX_STEP     = 12,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           center,
  output logic [Y_W-1:0] paddle_y,
  output logic           paddle_moving,
  output logic           at_top,
  output logic           at_bottom
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W-1:0] Y_INIT = Y_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [Y_W-1:0] STEP_V = Y_W'(STEP);

  logic [1:0]     state_q, state_d;
  logic [1:0]     dir;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W:0]   down_sum;
  logic           moving_q, at_top_q, at_bottom_q;

  always_comb begin
    dir = ST_IDLE;
    if (btn_up && !btn_down) begin
      dir = ST_UP;
    end else if (btn_down && !btn_up) begin
      dir = ST_DOWN;
    end
  end

`ifdef PADDLE_ACCEL_EN
  localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
  localparam logic [Y_W:0] MAX_STEP_W = (Y_W+1)'(MAX_STEP);

  logic [Y_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [Y_W:0] step_inc;

  assign step_inc = {1'b0, step_q} + {1'b0, STEP_V};

  // The move on a tick always uses the step decided on that same tick.
  always_comb begin
    step_d = step_q;
    hold_d = hold_q;
    if (center) begin
      step_d = STEP_V;
      hold_d = '0;
    end else if (frame_tick) begin
      if (dir == ST_IDLE || dir != state_q) begin
        step_d = STEP_V;
        hold_d = '0;
      end else if (hold_q == CNT_W'(ACCEL_FRAMES - 1)) begin
        hold_d = '0;
        step_d = (step_inc > MAX_STEP_W) ? MAX_STEP_W[Y_W-1:0] : step_inc[Y_W-1:0];
      end else begin
        hold_d = hold_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= STEP_V;
      hold_q <= '0;
    end else begin
      step_q <= step_d;
      hold_q <= hold_d;
    end
  end
`else
  logic [Y_W-1:0] step_d;
  assign step_d = STEP_V;
`endif

  // Down move is evaluated one bit wider so it can never wrap.
  assign down_sum = {1'b0, y_q} + {1'b0, step_d};

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    if (center) begin
      state_d = ST_IDLE;
      y_d     = Y_INIT;
    end else if (frame_tick) begin
      state_d = dir;
      case (dir)
        ST_UP:   y_d = (y_q < step_d) ? '0 : (y_q - step_d);
        ST_DOWN: y_d = (down_sum > {1'b0, Y_MAX}) ? Y_MAX : down_sum[Y_W-1:0];
        default: y_d = y_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      y_q         <= Y_INIT;
      moving_q    <= 1'b0;
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      moving_q    <= (state_d != ST_IDLE);
      at_top_q    <= (y_d == '0);
      at_bottom_q <= (y_d == Y_MAX);
    end
  end

  assign paddle_y      = y_q;
  assign paddle_moving = moving_q;
  assign at_top        = at_top_q;
  assign at_bottom     = at_bottom_q;

endmodule

// File: tb/tb_paddle_controller.sv
// tb/tb_paddle_controller.sv - directed self-checking bench for paddle_controller
module tb_paddle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       center;
  logic [9:0] paddle_y;
  logic       paddle_moving;
  logic       at_top;
  logic       at_bottom;

  int n_chk = 0;
  int n_err = 0;

  paddle_controller dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .center       (center),
    .paddle_y     (paddle_y),
    .paddle_moving(paddle_moving),
    .at_top       (at_top),
    .at_bottom    (at_bottom)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_chk++;
    if (observed != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One frame tick followed by one idle cycle; returns #1 after a posedge.
  task automatic do_tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_state(input string tag, input int y, input int mv, input int top, input int bot);
    check({tag, ".y"}, int'(paddle_y), y);
    check({tag, ".moving"}, int'(paddle_moving), mv);
    check({tag, ".at_top"}, int'(at_top), top);
    check({tag, ".at_bottom"}, int'(at_bottom), bot);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check_state("rst_mid", 200, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_y;
    rst = 1'b1; frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; center = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_state("reset", 200, 0, 0, 0);

    // Idle cycles without a tick never move the paddle.
    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_tick.y", int'(paddle_y), 200);

`ifndef PADDLE_ACCEL_EN
    exp_y = 200;
    for (int k = 0; k < 10; k++) begin
      do_tick();
      exp_y -= 4;
      check($sformatf("up_run[%0d]", k), int'(paddle_y), exp_y);
    end
    check_state("up_run_end", 160, 1, 0, 0);

    pulse_reset();

    repeat (50) do_tick();
    check_state("reach_top", 0, 1, 1, 0);
    repeat (2) do_tick();
    check_state("hold_top", 0, 1, 1, 0);

    btn_up = 1'b0; btn_down = 1'b1;
    do_tick();
    check_state("leave_top", 4, 1, 0, 0);
    repeat (99) do_tick();
    check_state("reach_bottom", 400, 1, 0, 1);
    repeat (3) do_tick();
    check_state("hold_bottom", 400, 1, 0, 1);

    btn_up = 1'b1;
    do_tick();
    check_state("both_held", 400, 0, 0, 1);

    // Up pressed only between ticks must be ignored.
    btn_down = 1'b0;
    @(posedge clk); #1;
    btn_up = 1'b0;
    do_tick();
    check_state("between_ticks", 400, 0, 0, 1);

    btn_down = 1'b1;
    center = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    center = 1'b0; frame_tick = 1'b0;
    check_state("center_tick", 200, 0, 0, 0);

    btn_down = 1'b0; btn_up = 1'b1;
    do_tick();
    check_state("after_center", 196, 1, 0, 0);
    center = 1'b1;
    @(posedge clk); #1;
    center = 1'b0;
    check_state("center_only", 200, 0, 0, 0);
`else
    repeat (30) do_tick();
    check_state("accel_top", 0, 1, 1, 0);
    btn_up = 1'b0;
    do_tick();
    check_state("accel_idle", 0, 0, 1, 0);

    btn_down = 1'b1;
    exp_y = 0;
    for (int k = 0; k < 24; k++) begin
      do_tick();
      exp_y += (k < 8) ? 4 : ((k < 16) ? 8 : 12);
      check($sformatf("accel_down[%0d]", k), int'(paddle_y), exp_y);
    end
    check_state("accel_192", 192, 1, 0, 0);

    btn_down = 1'b0;
    do_tick();
    check_state("accel_release", 192, 0, 0, 0);
    btn_down = 1'b1;
    do_tick();
    check_state("accel_repress", 196, 1, 0, 0);

    // Reversal drops back to base speed on the same tick.
    repeat (9) do_tick();
    check("accel_second", int'(paddle_y), 196 + 7 * 4 + 8 + 8);
    btn_down = 1'b0; btn_up = 1'b1;
    do_tick();
    check("accel_reverse", int'(paddle_y), 240 - 4);

    pulse_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
